// File: rtl/fixed_pkg.sv
// Shared fixed-point types: rounding and overflow mode selectors plus legal parameter bounds.
package fixed_pkg;

  typedef enum logic {
    ROUND_TRUNC,
    ROUND_NEAREST
  } round_mode_e;

  typedef enum logic {
    OVF_WRAP,
    OVF_SATURATE
  } ovf_mode_e;

  localparam int unsigned MIN_TOTAL_BITS = 2;
  localparam int unsigned MAX_TOTAL_BITS = 32;
  localparam int unsigned MIN_STAGES     = 1;
  localparam int unsigned MAX_STAGES     = 4;

endpackage

// File: rtl/fixed_mul_core.sv
// Combinational unsigned fixed-point multiply: exact product, optional half-up rounding,
// rescale by the fractional width, then overflow detect with wrap or saturate.
module fixed_mul_core
  import fixed_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = 24,
  parameter int unsigned FRACTIONAL_BITS = 16,
  parameter round_mode_e ROUND           = ROUND_TRUNC,
  parameter ovf_mode_e   OVERFLOW        = OVF_WRAP
) (
  input  logic [TOTAL_BITS-1:0] a,
  input  logic [TOTAL_BITS-1:0] b,
  output logic [TOTAL_BITS-1:0] result_c,
  output logic                  overflow_c
);

  localparam int unsigned PW = 2 * TOTAL_BITS;

  // Half an output LSB; the shift pair yields zero when there are no fractional bits.
  localparam logic [PW-1:0] HALF_LSB = (PW'(1) << FRACTIONAL_BITS) >> 1;
  localparam logic [PW-1:0] RND_ADD  = (ROUND == ROUND_NEAREST) ? HALF_LSB : '0;

  logic [PW-1:0] product_c;
  logic [PW-1:0] rounded_c;
  logic [PW-1:0] shifted_c;

  // The rounding constant is below 2^TOTAL_BITS, so the sum cannot carry out of PW bits.
  always_comb begin
    product_c  = PW'(a) * PW'(b);
    rounded_c  = product_c + RND_ADD;
    shifted_c  = rounded_c >> FRACTIONAL_BITS;
    overflow_c = |shifted_c[PW-1:TOTAL_BITS];
    result_c   = shifted_c[TOTAL_BITS-1:0];
    if (overflow_c && (OVERFLOW == OVF_SATURATE)) begin
      result_c = '1;
    end
  end

endmodule

// File: rtl/fixed_mul_pipe.sv
// Pipelined unsigned fixed-point multiplier with valid/ready flow control; the whole
// pipeline advances together whenever the output slot is empty or being drained.
module fixed_mul_pipe
  import fixed_pkg::*;
#(
  parameter int unsigned TOTAL_BITS      = 24,
  parameter int unsigned FRACTIONAL_BITS = 16,
  parameter int unsigned STAGES          = 2,
  parameter round_mode_e ROUND           = ROUND_TRUNC,
  parameter ovf_mode_e   OVERFLOW        = OVF_WRAP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TOTAL_BITS-1:0] in1,
  input  logic [TOTAL_BITS-1:0] in2,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [TOTAL_BITS-1:0] out,
  output logic                  out_overflow,
  output logic                  out_valid,
  input  logic                  out_ready
);

  if ((TOTAL_BITS < MIN_TOTAL_BITS) || (TOTAL_BITS > MAX_TOTAL_BITS) ||
      (FRACTIONAL_BITS >= TOTAL_BITS) ||
      (STAGES < MIN_STAGES) || (STAGES > MAX_STAGES)) begin : g_param_check
    $error("fixed_mul_pipe: illegal TOTAL_BITS/FRACTIONAL_BITS/STAGES combination");
  end

  logic [TOTAL_BITS-1:0] core_result_c;
  logic                  core_overflow_c;
  logic                  advance_c;

  logic [TOTAL_BITS-1:0] data_q [STAGES];
  logic [STAGES-1:0]     ovf_q;
  logic [STAGES-1:0]     vld_q;

  fixed_mul_core #(
    .TOTAL_BITS      (TOTAL_BITS),
    .FRACTIONAL_BITS (FRACTIONAL_BITS),
    .ROUND           (ROUND),
    .OVERFLOW        (OVERFLOW)
  ) u_core (
    .a          (in1),
    .b          (in2),
    .result_c   (core_result_c),
    .overflow_c (core_overflow_c)
  );

  // Bubbles are not collapsed, so acceptance is exactly the global advance condition.
  assign advance_c = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance_c;

  // Stage 0 captures the core result; later stages are pure delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        data_q[i] <= '0;
      end
      ovf_q <= '0;
      vld_q <= '0;
    end else if (advance_c) begin
      data_q[0] <= core_result_c;
      ovf_q[0]  <= core_overflow_c;
      vld_q[0]  <= in_valid;
      for (int i = 1; i < int'(STAGES); i++) begin
        data_q[i] <= data_q[i-1];
        ovf_q[i]  <= ovf_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign out          = data_q[STAGES-1];
  assign out_overflow = ovf_q[STAGES-1];
  assign out_valid    = vld_q[STAGES-1];

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// Bench for fixed_mul_pipe in Q4.3 (7 bits, 3 fractional, 2 stages): a truncate/wrap and a
// round/saturate instance share stimulus and are checked against an arithmetic model.
module tb_fixed_mul_pipe;
  import fixed_pkg::*;

  localparam int W = 7;
  localparam int F = 3;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready_a, in_ready_b;
  logic [W-1:0] out_a, out_b;
  logic         ovf_a, ovf_b;
  logic         out_valid_a, out_valid_b;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  typedef struct {
    int a;
    int b;
  } pair_t;
  pair_t pending[$];

  always #5 clk = ~clk;

  fixed_mul_pipe #(
    .TOTAL_BITS(W), .FRACTIONAL_BITS(F), .STAGES(S),
    .ROUND(ROUND_TRUNC), .OVERFLOW(OVF_WRAP)
  ) dut_a (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(in_ready_a), .out(out_a), .out_overflow(ovf_a),
    .out_valid(out_valid_a), .out_ready(out_ready)
  );

  fixed_mul_pipe #(
    .TOTAL_BITS(W), .FRACTIONAL_BITS(F), .STAGES(S),
    .ROUND(ROUND_NEAREST), .OVERFLOW(OVF_SATURATE)
  ) dut_b (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2), .in_valid(in_valid),
    .in_ready(in_ready_b), .out(out_b), .out_overflow(ovf_b),
    .out_valid(out_valid_b), .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Real-number view of the format: value = a*b / 2^F, optionally rounded half-up.
  function automatic void model(input int a, input int b, input bit nearest, input bit sat,
                                output int res, output bit ovf);
    longint p;
    longint s;
    p = longint'(a) * longint'(b);
    if (nearest && F > 0) p = p + (longint'(1) << (F - 1));
    s = p / (longint'(1) << F);
    ovf = (s >= (longint'(1) << W));
    if (ovf && sat) res = (1 << W) - 1;
    else res = int'(s % (longint'(1) << W));
  endfunction

  // Per-cycle scoreboard, sampled on the falling edge.
  bit           stalled = 1'b0;
  logic [W-1:0] held_a, held_b;
  logic         held_oa, held_ob;
  always @(negedge clk) begin
    int  ra, rb;
    bit  oa, ob;
    if (reset) begin
      pending.delete();
      stalled = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready_a, !out_valid_a || out_ready);
      chk("in_ready_b", in_ready_b, in_ready_a);
      chk("out_valid_b", out_valid_b, out_valid_a);
      if (stalled) begin
        chk("hold_valid", out_valid_a, 1);
        chk("hold_out_a", out_a, held_a);
        chk("hold_ovf_a", ovf_a, held_oa);
        chk("hold_out_b", out_b, held_b);
        chk("hold_ovf_b", ovf_b, held_ob);
      end
      if (out_valid_a) begin
        chk("result_pending", pending.size() > 0, 1);
        if (pending.size() > 0) begin
          model(pending[0].a, pending[0].b, 1'b0, 1'b0, ra, oa);
          model(pending[0].a, pending[0].b, 1'b1, 1'b1, rb, ob);
          chk("model_out_a", out_a, ra);
          chk("model_ovf_a", ovf_a, oa);
          chk("model_out_b", out_b, rb);
          chk("model_ovf_b", ovf_b, ob);
          if (out_ready) begin
            void'(pending.pop_front());
            delivered++;
          end
        end
      end
      stalled = out_valid_a && !out_ready;
      held_a = out_a; held_b = out_b; held_oa = ovf_a; held_ob = ovf_b;
      if (in_valid && in_ready_a) pending.push_back('{a: int'(in1), b: int'(in2)});
    end
  end

  // One pair into an empty pipeline: result must appear exactly S cycles after acceptance.
  task automatic single(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ea, input logic oa,
                        input logic [W-1:0] eb, input logic ob);
    @(posedge clk); #1;
    in1 = a; in2 = b; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, in_ready_a, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_not_early"}, out_valid_a, 0);
    @(negedge clk);
    chk({nm, "_valid"}, out_valid_a, 1);
    chk({nm, "_out_trunc_wrap"}, out_a, ea);
    chk({nm, "_ovf_trunc_wrap"}, ovf_a, oa);
    chk({nm, "_out_near_sat"}, out_b, eb);
    chk({nm, "_ovf_near_sat"}, ovf_b, ob);
  endtask

  logic [W-1:0] sa [8] = '{7'd12, 7'd120, 7'd120, 7'd1, 7'd127, 7'd0, 7'd9, 7'd64};
  logic [W-1:0] sb [8] = '{7'd16, 7'd4, 7'd16, 7'd4, 7'd127, 7'd55, 7'd9, 7'd2};

  initial begin
    int idx;
    int stall_low;
    bit acc;

    // Reset state
    #2;
    chk("reset_out_valid", out_valid_a, 0);
    chk("reset_out", out_a, 0);
    chk("reset_ovf", ovf_a, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", in_ready_a, 1);

    // Hand-computed directed vectors
    single("mul_1p5x2", 7'b0001100, 7'b0010000, 7'b0011000, 1'b0, 7'b0011000, 1'b0);
    single("mul_15xhalf", 7'b1111000, 7'b0000100, 7'b0111100, 1'b0, 7'b0111100, 1'b0);
    single("mul_15x2_ovf", 7'b1111000, 7'b0010000, 7'b1110000, 1'b1, 7'b1111111, 1'b1);
    single("mul_round", 7'b0000001, 7'b0000100, 7'b0000000, 1'b0, 7'b0000001, 1'b0);
    single("mul_zero", 7'b0000000, 7'b1111111, 7'b0000000, 1'b0, 7'b0000000, 1'b0);

    // Back-to-back stream of 8 with a 3-cycle output stall
    @(posedge clk); #1;
    delivered = 0;
    idx = 0;
    stall_low = 0;
    for (int cyc = 0; cyc < 40 && (idx < 8 || delivered < 8); cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid = (idx < 8);
      if (idx < 8) begin
        in1 = sa[idx];
        in2 = sb[idx];
      end
      @(negedge clk);
      if (!out_ready) begin
        chk("stall_in_ready", in_ready_a, 0);
        if (!in_ready_a) stall_low++;
      end
      acc = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_accepted", idx, 8);
    chk("stream_delivered", delivered, 8);
    chk("stream_stall_cycles", stall_low, 3);
    chk("stream_drained", pending.size(), 0);

    // Reset with two results in flight
    in1 = 7'd12; in2 = 7'd16; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in1 = 7'd120; in2 = 7'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("inflight_valid", out_valid_a, 1);
    reset = 1'b1;
    #1;
    chk("async_reset_valid_a", out_valid_a, 0);
    chk("async_reset_valid_b", out_valid_b, 0);
    chk("async_reset_out", out_a, 0);
    chk("async_reset_ovf", ovf_b, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("after_reset_in_ready", in_ready_a, 1);
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_after_reset", out_valid_a, 0);
    end
    single("first_after_reset", 7'b0000011, 7'b0001000, 7'b0000011, 1'b0, 7'b0000011, 1'b0);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fixed_mul_pipe.md
FIXED_MUL_PIPE -- requirements
Module: fixed_mul_pipe

Interface
REQ-001 SHALL have parameter TOTAL_BITS, default 24: operand/result width in bits (unsigned fixed point), legal range 2..32.
REQ-002 SHALL have parameter FRACTIONAL_BITS, default 16: fractional bits of operands and result, legal range 0..TOTAL_BITS-1.
REQ-003 SHALL have parameter STAGES, default 2: register stages from input acceptance to output, legal range 1..4.
REQ-004 SHALL have parameter ROUND, default fixed_pkg::ROUND_TRUNC: ROUND_TRUNC drops discarded bits; ROUND_NEAREST rounds half-up.
REQ-005 SHALL have parameter OVERFLOW, default fixed_pkg::OVF_WRAP: OVF_WRAP keeps low result bits; OVF_SATURATE clamps to all-ones.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in1, input, TOTAL_BITS: multiplicand.
REQ-009 SHALL have port in2, input, TOTAL_BITS: multiplier.
REQ-010 SHALL have port in_valid, input, 1: in1/in2 carry a valid operand pair.
REQ-011 SHALL have port in_ready, output, 1: block accepts a pair this cycle.
REQ-012 SHALL have port out, output, TOTAL_BITS: product in the same Q format as the inputs.
REQ-013 SHALL have port out_overflow, output, 1: true product did not fit in TOTAL_BITS after rounding.
REQ-014 SHALL have port out_valid, output, 1: out/out_overflow hold a valid result.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the result this cycle.

Function
REQ-016 SHALL form the exact 2*TOTAL_BITS-bit product in1*in2 with no intermediate truncation.
REQ-017 SHALL, for ROUND_NEAREST with FRACTIONAL_BITS>0, add 2^(FRACTIONAL_BITS-1) to the full product before shifting; for ROUND_TRUNC or FRACTIONAL_BITS=0, add nothing.
REQ-018 SHALL shift the (rounded) product right by FRACTIONAL_BITS; bits above TOTAL_BITS-1 of the shifted value being non-zero SHALL set out_overflow=1.
REQ-019 SHALL output the low TOTAL_BITS bits on overflow under OVF_WRAP, and all-ones under OVF_SATURATE; out_overflow SHALL be reported in both modes.
REQ-020 SHALL accept a pair when in_valid && in_ready, and present its result with out_valid=1 exactly STAGES cycles later when no stall occurs.
REQ-021 SHALL advance the whole pipeline on a cycle where advance = !out_valid || out_ready, and hold every stage (data and valid) otherwise.
REQ-022 SHALL drive in_ready = advance (combinational from out_valid and out_ready); in_ready SHALL not depend on in_valid.
REQ-023 SHALL sustain one result per cycle while in_valid and out_ready are both held high.
REQ-024 SHALL hold out and out_overflow stable while out_valid && !out_ready; a result SHALL be delivered exactly once.
REQ-025 SHALL propagate bubbles as invalid stages; bubble collapsing during stalls is not required.
REQ-026 SHALL preserve input order of results; no reordering, drop or duplication.

Reset
REQ-027 SHALL, while reset is high, clear all stage valid bits asynchronously: out_valid=0, out=0, out_overflow=0.
REQ-028 SHALL discard all in-flight operands on reset mid-operation; the first post-reset result SHALL come from the first pair accepted after reset deasserts.
REQ-029 SHALL drive in_ready=1 in the first cycle after reset deasserts.

Structure
REQ-030 SHALL take enums round_mode_e {ROUND_TRUNC, ROUND_NEAREST} and ovf_mode_e {OVF_WRAP, OVF_SATURATE} from shared package fixed_pkg.
REQ-031 SHALL place the combinational multiply/round/overflow datapath in sub-module fixed_mul_core, registered once at the pipeline input and then through STAGES-1 delay stages.
REQ-032 SHALL reject illegal parameter combinations with an elaboration-time assertion.

Verification (TOTAL_BITS=7, FRACTIONAL_BITS=3, STAGES=2 unless stated)
REQ-033 SHALL cover in1=0001100 (1.5), in2=0010000 (2.0) -> out=0011000 (3.0), out_overflow=0, out_valid 2 cycles after acceptance.
REQ-034 SHALL cover in1=1111000 (15.0), in2=0000100 (0.5) -> out=0111100 (7.5), out_overflow=0.
REQ-035 SHALL cover in1=1111000 (15.0), in2=0010000 (2.0) -> OVF_WRAP: out=1110000 (14.0), out_overflow=1; OVF_SATURATE: out=1111111, out_overflow=1.
REQ-036 SHALL cover in1=0000001 (0.125), in2=0000100 (0.5) -> ROUND_TRUNC out=0000000; ROUND_NEAREST out=0000001.
REQ-037 SHALL cover back-to-back stream of 8 pairs with out_ready low for 3 cycles mid-stream -> in_ready=0 during the stall, out held, all 8 results in order, none lost or duplicated.
REQ-038 SHALL cover reset asserted with 2 results in flight -> out_valid=0 immediately, no stale result after reset deasserts.
